reg_shift_out: RTL and testbench
================================

REG_SHIFT_OUT -- requirements
Module: reg_shift_out

Interface
REQ-001 Parameter WIDTH, default 16: word width in bits; SHALL be >= 2.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 load  input  1  request to capture d_in; honoured only while ready=1.
REQ-006 d_in  input  WIDTH  parallel word to serialise.
REQ-007 ready  output  1  unit can accept a word this cycle (combinational).
REQ-008 s_out  output  1  current serial bit (registered).
REQ-009 s_valid  output  1  s_out holds a valid bit (registered).
REQ-010 s_ready  input  1  consumer accepts the current bit; a transfer occurs when s_valid & s_ready.
REQ-011 s_last  output  1  current bit is the final bit of the word (registered).
REQ-012 busy  output  1  a word is in flight (state SHIFT).

Function
REQ-013 FSM states: IDLE, SHIFT.
REQ-014 IDLE: ready=1, s_valid=0, s_last=0, busy=0; load=1 captures d_in, clears the bit count, and enters SHIFT.
REQ-015 Latency: load accepted in cycle N -> first bit on s_out with s_valid=1 in cycle N+1.
REQ-016 SHIFT: s_valid=1; s_out = the next unsent bit in the order set by MSB_FIRST.
REQ-017 On each transfer the shift register advances one position and the bit count increments by 1.
REQ-018 While s_ready=0, s_out, s_valid, s_last and the count SHALL hold unchanged.
REQ-019 s_last=1 exactly when count = WIDTH-1; count width = clog2(WIDTH); the count never exceeds WIDTH-1.
REQ-020 ready = (state==IDLE) | (state==SHIFT & s_last & s_ready).
REQ-021 On transfer of the last bit with load=1, the new d_in SHALL be captured and its first bit presented the next cycle, staying in SHIFT with no idle gap.
REQ-022 On transfer of the last bit with load=0, the FSM enters IDLE and s_valid falls the next cycle.
REQ-023 load while ready=0 SHALL be ignored; the in-flight word is not disturbed.
REQ-024 With s_ready held high, one word occupies exactly WIDTH consecutive cycles of s_valid.
REQ-025 Values vacated by shifting SHALL be filled with 0.

Reset
REQ-026 While reset=1, the block SHALL immediately force: state=IDLE, shift register=0, count=0, s_out=0, s_valid=0, s_last=0, busy=0.
REQ-027 Reset mid-word SHALL abort the word; no remaining bits are emitted after reset deasserts.
REQ-028 The first load is accepted on the first rising edge after reset deasserts.

Structure
REQ-029 A shared package reg_shift_pkg SHALL hold the state encoding (IDLE=0, SHIFT=1) and the default WIDTH constant 16.
REQ-030 One sub-module, shift_bit_counter (mod-WIDTH counter with clear, enable and terminal-count output driving s_last), is natural; everything else is inline.

Verification
REQ-031 WIDTH=16, MSB_FIRST=1, s_ready=1, load 0xA5C3 -> s_out 1010_0101_1100_0011 over cycles 1-16; s_last only in cycle 16; s_valid=0 in cycle 17.
REQ-032 MSB_FIRST=0, load 0x0001 -> s_out=1 in cycle 1, then 0 for cycles 2-16.
REQ-033 Backpressure: load 0xA5C3 with s_ready=0 during cycles 3-5 -> s_out held at bit 13 (value 1) across those cycles; word completes in cycle 19.
REQ-034 Back-to-back: load 0xFFFF, then load 0x0001 with the 16th bit -> 16 ones followed immediately by fifteen 0s and a 1; s_valid never drops between words.
REQ-035 Load 0x1234 while busy at bit 5 -> ignored; the original word completes unchanged.
REQ-036 Reset pulse during bit 7 -> all outputs 0 within the same cycle; after release, s_valid stays 0 until a new load.

Source files
------------

// File: rtl/reg_shift_pkg.sv
// Shared definitions for the parallel-to-serial shifter: state encoding and default word width.
package reg_shift_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage : reg_shift_pkg

// File: rtl/shift_bit_counter.sv
// Mod-WIDTH bit counter with synchronous clear and enable; tc flags the final bit position.
module shift_bit_counter
  import reg_shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count;

  // tc is registered alongside count so it is high exactly while count == WIDTH-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      tc    <= 1'b0;
    end else if (clr) begin
      count <= '0;
      tc    <= 1'b0;
    end else if (en) begin
      if (tc) begin
        count <= '0;
        tc    <= 1'b0;
      end else begin
        count <= count + CW'(1);
        tc    <= ((count + CW'(1)) == LAST);
      end
    end
  end

endmodule : shift_bit_counter

// File: rtl/reg_shift_out.sv
// Parallel-to-serial shifter with valid/ready handshake on the serial side and
// zero-gap back-to-back word loading on the final bit.
module reg_shift_out
  import reg_shift_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  output logic             ready,
  output logic             s_out,
  output logic             s_valid,
  input  logic             s_ready,
  output logic             s_last,
  output logic             busy
);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic             xfer;
  logic             load_acc;

  assign xfer     = s_valid & s_ready;
  assign ready    = (state == IDLE) | ((state == SHIFT) & s_last & s_ready);
  assign load_acc = load & ready;

  // Vacated positions fill with zero, so the register drains to all-zero after a word.
  assign shreg_next = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  assign s_out   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign s_valid = (state == SHIFT);
  assign busy    = (state == SHIFT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_acc) begin
            shreg <= d_in;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (xfer) begin
            if (load_acc) begin
              shreg <= d_in;
            end else begin
              shreg <= shreg_next;
              if (s_last) state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A reload on the last bit restarts the count instead of wrapping it.
  shift_bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (load_acc),
    .en   (xfer & ~load_acc),
    .tc   (s_last)
  );

endmodule : reg_shift_out

// File: tb/tb_reg_shift_out.sv
// Directed bench for reg_shift_out: one MSB-first and one LSB-first instance, WIDTH=16.
module tb_reg_shift_out;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_m;
  logic         load_l;
  logic         s_ready;
  logic [W-1:0] d_in;

  logic ready_m, s_out_m, s_valid_m, s_last_m, busy_m;
  logic ready_l, s_out_l, s_valid_l, s_last_l, busy_l;
  logic [4:0] obs_m;
  logic [4:0] obs_l;

  int n_checks = 0;
  int n_fail   = 0;

  assign obs_m = {busy_m, ready_m, s_valid_m, s_last_m, s_out_m};
  assign obs_l = {busy_l, ready_l, s_valid_l, s_last_l, s_out_l};

  always #5 clk = ~clk;

  reg_shift_out #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .load(load_m), .d_in(d_in), .ready(ready_m),
    .s_out(s_out_m), .s_valid(s_valid_m), .s_ready(s_ready), .s_last(s_last_m), .busy(busy_m)
  );

  reg_shift_out #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .load(load_l), .d_in(d_in), .ready(ready_l),
    .s_out(s_out_l), .s_valid(s_valid_l), .s_ready(s_ready), .s_last(s_last_l), .busy(busy_l)
  );

  // Each task starts just after a rising edge and leaves just after one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observation vector order: {busy, ready, s_valid, s_last, s_out}.
  task automatic test_reset();
    reset = 1'b1; load_m = 1'b0; load_l = 1'b0; s_ready = 1'b1; d_in = '0;
    tick(); tick();
    #1;
    n_checks++;
    if (obs_m !== 5'b01000) begin
      n_fail++; $display("FAIL reset_msb: got %b expected %b", obs_m, 5'b01000);
    end
    n_checks++;
    if (obs_l !== 5'b01000) begin
      n_fail++; $display("FAIL reset_lsb: got %b expected %b", obs_l, 5'b01000);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_msb_basic();
    logic [W-1:0] word;
    logic [4:0]   exp;
    word = 16'hA5C3;
    load_m = 1'b1; d_in = word; s_ready = 1'b1;
    tick();
    load_m = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      #1;
      exp = {1'b1, (c == 16), 1'b1, (c == 16), word[W-c]};
      n_checks++;
      if (obs_m !== exp) begin
        n_fail++; $display("FAIL msb_basic cycle %0d: got %b expected %b", c, obs_m, exp);
      end
      tick();
    end
    #1;
    n_checks++;
    if (obs_m !== 5'b01000) begin
      n_fail++; $display("FAIL msb_basic end: got %b expected %b", obs_m, 5'b01000);
    end
  endtask

  task automatic test_lsb_first();
    logic [4:0] exp;
    load_l = 1'b1; d_in = 16'h0001; s_ready = 1'b1;
    tick();
    load_l = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      #1;
      exp = {1'b1, (c == 16), 1'b1, (c == 16), (c == 1)};
      n_checks++;
      if (obs_l !== exp) begin
        n_fail++; $display("FAIL lsb_first cycle %0d: got %b expected %b", c, obs_l, exp);
      end
      tick();
    end
    #1;
    n_checks++;
    if (obs_l !== 5'b01000) begin
      n_fail++; $display("FAIL lsb_first end: got %b expected %b", obs_l, 5'b01000);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] word;
    logic [4:0]   exp;
    int           k;
    word = 16'hA5C3; k = 0;
    load_m = 1'b1; d_in = word; s_ready = 1'b1;
    tick();
    load_m = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      s_ready = !(c >= 3 && c <= 5);
      #1;
      exp = {1'b1, (k == 15) && s_ready, 1'b1, (k == 15), word[15-k]};
      n_checks++;
      if (obs_m !== exp) begin
        n_fail++; $display("FAIL backpressure cycle %0d: got %b expected %b", c, obs_m, exp);
      end
      if (s_ready) k++;
      tick();
    end
    s_ready = 1'b1;
    #1;
    n_checks++;
    if (obs_m !== 5'b01000) begin
      n_fail++; $display("FAIL backpressure end: got %b expected %b", obs_m, 5'b01000);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp;
    logic       last;
    load_m = 1'b1; d_in = 16'hFFFF; s_ready = 1'b1;
    tick();
    for (int c = 1; c <= 32; c++) begin
      if (c == 16) begin
        load_m = 1'b1; d_in = 16'h0001;
      end else begin
        load_m = 1'b0;
      end
      #1;
      last = (c == 16) || (c == 32);
      exp  = {1'b1, last, 1'b1, last, (c <= 16) || (c == 32)};
      n_checks++;
      if (obs_m !== exp) begin
        n_fail++; $display("FAIL back_to_back cycle %0d: got %b expected %b", c, obs_m, exp);
      end
      tick();
    end
    load_m = 1'b0;
    #1;
    n_checks++;
    if (obs_m !== 5'b01000) begin
      n_fail++; $display("FAIL back_to_back end: got %b expected %b", obs_m, 5'b01000);
    end
  endtask

  task automatic test_load_ignored();
    logic [W-1:0] word;
    logic [4:0]   exp;
    word = 16'hA5C3;
    load_m = 1'b1; d_in = word; s_ready = 1'b1;
    tick();
    for (int c = 1; c <= 16; c++) begin
      if (c == 5) begin
        load_m = 1'b1; d_in = 16'h1234;
      end else begin
        load_m = 1'b0;
      end
      #1;
      exp = {1'b1, (c == 16), 1'b1, (c == 16), word[W-c]};
      n_checks++;
      if (obs_m !== exp) begin
        n_fail++; $display("FAIL load_ignored cycle %0d: got %b expected %b", c, obs_m, exp);
      end
      tick();
    end
    #1;
    n_checks++;
    if (obs_m !== 5'b01000) begin
      n_fail++; $display("FAIL load_ignored end: got %b expected %b", obs_m, 5'b01000);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] word;
    logic [4:0]   exp;
    word = 16'hA5C3;
    load_m = 1'b1; d_in = word; s_ready = 1'b1;
    tick();
    load_m = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      #1;
      exp = {1'b1, 1'b0, 1'b1, 1'b0, word[W-c]};
      n_checks++;
      if (obs_m !== exp) begin
        n_fail++; $display("FAIL reset_mid pre cycle %0d: got %b expected %b", c, obs_m, exp);
      end
      if (c < 7) tick();
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (obs_m !== 5'b01000) begin
      n_fail++; $display("FAIL reset_mid async: got %b expected %b", obs_m, 5'b01000);
    end
    tick();
    reset = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_checks++;
      if (obs_m !== 5'b01000) begin
        n_fail++; $display("FAIL reset_mid after cycle %0d: got %b expected %b", c, obs_m, 5'b01000);
      end
    end
    load_m = 1'b1; d_in = 16'h8000;
    tick();
    load_m = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      #1;
      exp = {1'b1, (c == 16), 1'b1, (c == 16), (c == 1)};
      n_checks++;
      if (obs_m !== exp) begin
        n_fail++; $display("FAIL reset_mid reload cycle %0d: got %b expected %b", c, obs_m, exp);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_msb_basic();
    test_lsb_first();
    test_backpressure();
    test_back_to_back();
    test_load_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_reg_shift_out
